// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: one-cycle add/sub/logic, iterative shift-add multiply and
// restoring divide/remainder, with a start/busy/done handshake and status flags.
module ula_multiciclo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ULAOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int unsigned CW   = $clog2(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;

  typedef enum logic [0:0] {IDLE, CALC} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             busy_d, done_d, zero_d, carry_d, overflow_d, dbz_d;
  logic [WIDTH-1:0] result_d;

  logic [WIDTH:0]   sum, diff, rtrial;
  logic [PW-1:0]    prod_step;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             fits;

  // One-cycle arithmetic and one iteration step of each iterative algorithm
  always_comb begin
    sum       = {1'b0, A} + {1'b0, B};
    diff      = {1'b0, A} - {1'b0, B};
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    rtrial    = {rem_q, quo_q[WIDTH-1]};
    fits      = (rtrial >= {1'b0, dvs_q});
    rem_step  = fits ? WIDTH'(rtrial - {1'b0, dvs_q}) : rtrial[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], fits};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    busy_d     = busy;
    done_d     = 1'b0;
    result_d   = result;
    zero_d     = zero;
    carry_d    = carry;
    overflow_d = overflow;
    dbz_d      = div_by_zero;

    case (state_q)
      IDLE: begin
        if (start) begin
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          dbz_d      = 1'b0;
          case (ULAOp)
            OP_ADD: begin
              result_d   = sum[WIDTH-1:0];
              carry_d    = sum[WIDTH];
              overflow_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
              done_d     = 1'b1;
            end
            OP_SUB: begin
              result_d   = diff[WIDTH-1:0];
              carry_d    = diff[WIDTH];
              overflow_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
              done_d     = 1'b1;
            end
            OP_AND: begin
              result_d = A & B;
              done_d   = 1'b1;
            end
            OP_OR: begin
              result_d = A | B;
              done_d   = 1'b1;
            end
            OP_XOR: begin
              result_d = A ^ B;
              done_d   = 1'b1;
            end
            default: begin
              // mul, div, rem: flags keep their old values until completion
              carry_d    = carry;
              overflow_d = overflow;
              dbz_d      = div_by_zero;
              op_d       = ULAOp;
              cnt_d      = '0;
              prod_d     = '0;
              mcand_d    = {{WIDTH{1'b0}}, A};
              mplier_d   = B;
              quo_d      = A;
              rem_d      = '0;
              dvs_d      = B;
              busy_d     = 1'b1;
              state_d    = CALC;
            end
          endcase
        end
      end

      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == OP_MUL) begin
          prod_d   = prod_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          quo_d = quo_step;
          rem_d = rem_step;
        end
        if (cnt_q == LAST) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          overflow_d = 1'b0;
          if (op_q == OP_MUL) begin
            result_d = prod_step[WIDTH-1:0];
            carry_d  = |prod_step[PW-1:WIDTH];
            dbz_d    = 1'b0;
          end else begin
            // B = 0 falls out of the algorithm: quotient all ones, remainder A
            result_d = (op_q == OP_DIV) ? quo_step : rem_step;
            carry_d  = 1'b0;
            dbz_d    = (dvs_q == '0);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (done_d) zero_d = (result_d == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      zero        <= 1'b1;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      busy        <= busy_d;
      done        <= done_d;
      result      <= result_d;
      zero        <= zero_d;
      carry       <= carry_d;
      overflow    <= overflow_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo: cycle-level arithmetic model checked every cycle,
// plus directed cases with hand-computed expectations.
module tb_ula_multiciclo;

  localparam int unsigned W = 8;
  localparam int MOD = 256;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   ULAOp;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         div_by_zero;

  ula_multiciclo #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .A(A), .B(B), .ULAOp(ULAOp),
    .busy(busy), .done(done), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model state: what the outputs must show in the current cycle
  bit m_calc = 1'b0;
  bit m_done = 1'b0;
  int m_done_cyc = 0;
  int m_res = 0, m_c = 0, m_v = 0, m_d = 0;
  int p_res = 0, p_c = 0, p_v = 0, p_d = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void ref_op(input int op, input int a, input int b,
                                 output int r, output int c, output int v, output int d);
    int sa, sb, t;
    sa = (a >= MOD / 2) ? a - MOD : a;
    sb = (b >= MOD / 2) ? b - MOD : b;
    r = 0; c = 0; v = 0; d = 0;
    case (op)
      0: begin
        t = a + b; r = t % MOD; c = int'(t >= MOD);
        t = sa + sb; v = int'(t >= MOD / 2 || t < -(MOD / 2));
      end
      1: begin
        t = a - b; r = (t + MOD) % MOD; c = int'(a < b);
        t = sa - sb; v = int'(t >= MOD / 2 || t < -(MOD / 2));
      end
      2: begin t = a * b; r = t % MOD; c = int'(t >= MOD); end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: if (b == 0) begin r = MOD - 1; d = 1; end else r = a / b;
      default: if (b == 0) begin r = a; d = 1; end else r = a % b;
    endcase
  endfunction

  // Model update on each rising edge
  always @(posedge clock) begin
    int r, c, v, d;
    bit idle_prev;
    cyc = cyc + 1;
    m_done = 1'b0;
    if (!reset_n) begin
      m_calc = 1'b0;
      m_res = 0; m_c = 0; m_v = 0; m_d = 0;
    end else begin
      idle_prev = !m_calc;
      if (m_calc && cyc == m_done_cyc) begin
        m_calc = 1'b0;
        m_res = p_res; m_c = p_c; m_v = p_v; m_d = p_d;
        m_done = 1'b1;
      end
      if (start && idle_prev) begin
        ref_op(int'(ULAOp), int'(A), int'(B), r, c, v, d);
        if (ULAOp == 3'd2 || ULAOp >= 3'd6) begin
          m_calc = 1'b1;
          m_done_cyc = cyc + W;
          p_res = r; p_c = c; p_v = v; p_d = d;
        end else begin
          m_res = r; m_c = c; m_v = v; m_d = d;
          m_done = 1'b1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clock) begin
    if (cyc > 0) begin
      check("done", int'(done), int'(m_done));
      check("busy", int'(busy), int'(m_calc));
      check("result", int'(result), m_res);
      check("zero", int'(zero), int'(m_res == 0));
      check("carry", int'(carry), m_c);
      check("overflow", int'(overflow), m_v);
      check("div_by_zero", int'(div_by_zero), m_d);
    end
  end

  task automatic do_op(input int op, input int a, input int b, input int er, input int ec,
                       input int ev, input int ed, input int elat, input bit poke);
    int lat, nbusy;
    @(posedge clock); #1;
    start = 1'b1; ULAOp = 3'(op); A = W'(a); B = W'(b);
    @(posedge clock); #1;
    start = 1'b0; ULAOp = 3'($urandom); A = W'($urandom); B = W'($urandom);
    lat = 0; nbusy = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (done) begin lat = i; break; end
      if (busy) nbusy++;
      if (poke && i == 3) begin start = 1'b1; ULAOp = 3'd0; end
      if (poke && i == 4) start = 1'b0;
    end
    check("latency", lat, elat);
    check("busy_cycles", nbusy, elat - 1);
    check("lit_result", int'(result), er);
    check("lit_zero", int'(zero), int'(er == 0));
    check("lit_carry", int'(carry), ec);
    check("lit_overflow", int'(overflow), ev);
    check("lit_div_by_zero", int'(div_by_zero), ed);
  endtask

  initial begin
    int ndone;
    reset_n = 1'b0; start = 1'b0; A = '0; B = '0; ULAOp = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_result", int'(result), 0);
    check("rst_zero", int'(zero), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    do_op(0, 3, 7, 10, 0, 0, 0, 1, 1'b0);
    do_op(1, 7, 3, 4, 0, 0, 0, 1, 1'b0);
    do_op(1, 3, 7, 252, 1, 0, 0, 1, 1'b0);
    do_op(0, 127, 1, 128, 0, 1, 0, 1, 1'b0);
    do_op(1, 5, 5, 0, 0, 0, 0, 1, 1'b0);
    do_op(2, 7, 3, 21, 0, 0, 0, 9, 1'b0);
    do_op(2, 20, 20, 144, 1, 0, 0, 9, 1'b1);
    repeat (3) @(negedge clock);
    check("held_after_ignored_start", int'(result), 144);
    do_op(6, 100, 7, 14, 0, 0, 0, 9, 1'b0);
    do_op(7, 100, 7, 2, 0, 0, 0, 9, 1'b0);
    do_op(6, 9, 0, 255, 0, 0, 1, 9, 1'b0);
    do_op(7, 9, 0, 9, 0, 0, 1, 9, 1'b0);
    do_op(3, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 1, 1'b0);
    do_op(4, 8'hF0, 8'h3C, 8'hFC, 0, 0, 0, 1, 1'b0);
    do_op(5, 8'hF0, 8'h3C, 8'hCC, 0, 0, 0, 1, 1'b0);

    // Back-to-back single-step ops: start held high gives done every cycle
    @(posedge clock); #1;
    start = 1'b1; ULAOp = 3'd0; A = W'($urandom); B = W'($urandom);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (i == 4) start = 1'b0;
      else begin ULAOp = 3'($urandom_range(0, 1)); A = W'($urandom); B = W'($urandom); end
      @(negedge clock);
      if (done) ndone++;
    end
    check("b2b_done_count", ndone, 5);

    // Reset in the middle of a multiply aborts it
    @(posedge clock); #1;
    start = 1'b1; ULAOp = 3'd2; A = 8'd7; B = 8'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(result), 0);
    check("abort_zero", int'(zero), 1);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      start   = 1'($urandom_range(0, 1));
      ULAOp   = 3'($urandom);
      A       = W'($urandom);
      B       = ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom);
      reset_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
    end
    @(posedge clock); #1;
    start = 1'b0; reset_n = 1'b1;
    repeat (12) @(posedge clock);
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
